// File: rtl/diff_demo_pkg.sv
// Shared types and defaults for the diff NN demo load path.
// Holds the scatter FSM state type, error-bit positions and the default
// channel count / buffer depth used by the buffer write scatter blocks.
package diff_demo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scatter_state_e;

  localparam int SCATTER_ERR_SHORT = 0;
  localparam int SCATTER_ERR_LONG  = 1;

  localparam int CONF_PE_COL       = 8;
  localparam int CONF_FM_BUF_DEPTH = 1024;

endpackage

// File: rtl/diff_scatter_lane_map.sv
// Combinational routing of one stream beat onto N_CH write channels.
// Beat index k selects channels k*LANES .. k*LANES+LANES-1; byte j feeds
// channel k*LANES+j. A byte is enabled only when its keep bit is set and
// its element index (count of kept bytes before it) is below the number
// of elements still owed to the command. n_wr_o reports how many lanes fire.
module diff_scatter_lane_map
  import diff_demo_pkg::*;
#(
  parameter int LANES      = 8,
  parameter int N_CH       = CONF_PE_COL,
  parameter int ELEM_WIDTH = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int KW         = 1,
  parameter int CW         = $clog2(LANES + 1)
) (
  input  logic [KW-1:0]                     beat_idx_i,
  input  logic [LANES*8-1:0]                tdata_i,
  input  logic [LANES-1:0]                  tkeep_i,
  input  logic [LEN_WIDTH-1:0]              remain_i,
  output logic [N_CH-1:0]                   ch_en_o,
  output logic [N_CH-1:0][ELEM_WIDTH-1:0]   ch_din_o,
  output logic [CW-1:0]                     n_wr_o
);

  logic [LANES-1:0]     lane_en;
  logic [LEN_WIDTH-1:0] prefix;

  // Per-lane enable: kept bytes are numbered in order and cut off at the remaining length
  always_comb begin
    lane_en = '0;
    prefix  = '0;
    n_wr_o  = '0;
    for (int j = 0; j < LANES; j++) begin
      if (tkeep_i[j]) begin
        if (prefix < remain_i) begin
          lane_en[j] = 1'b1;
          n_wr_o     = n_wr_o + CW'(1);
        end
        prefix = prefix + LEN_WIDTH'(1);
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    localparam int J  = c % LANES;
    localparam int KB = c / LANES;
    assign ch_din_o[c] = tdata_i[J*8 +: ELEM_WIDTH];
    assign ch_en_o[c]  = lane_en[J] && (beat_idx_i == KW'(KB));
  end

endmodule

// File: rtl/diff_stream_scatter.sv
// Scatters a DMA mm2s byte-packed payload round-robin over N_CH buffer
// write ports, one load command at a time. Writes are registered one cycle
// after each accepted beat; done pulses in the cycle of the last write.
// Optional feature macro: DIFF_SCATTER_CSUM_EN adds csum[31:0], the sum of
// all elements written by the current command.
module diff_stream_scatter
  import diff_demo_pkg::*;
#(
  parameter int  DATA_WIDTH = 64,
  parameter int  ELEM_WIDTH = 8,
  parameter int  N_CH       = CONF_PE_COL,
  parameter int  DEPTH      = CONF_FM_BUF_DEPTH,
  parameter int  LEN_WIDTH  = 16,
  localparam int LANES      = DATA_WIDTH / 8,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [AW-1:0]                    cmd_base_addr,
  input  logic [LEN_WIDTH-1:0]             cmd_len,
  input  logic                             cmd_ping_pong,
  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [LANES-1:0]                 s_axis_tkeep,
  input  logic                             s_axis_tlast,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic [N_CH-1:0][AW-1:0]          wr_addr,
  output logic [N_CH-1:0][ELEM_WIDTH-1:0]  wr_din,
  output logic [N_CH-1:0]                  wr_en,
  output logic [N_CH-1:0]                  wr_ping_pong,
  output logic                             done,
  output logic [1:0]                       err
`ifdef DIFF_SCATTER_CSUM_EN
  ,
  output logic [31:0]                      csum
`endif
);

  localparam int K  = N_CH / LANES;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int CW = $clog2(LANES + 1);

  if ((DATA_WIDTH % 8) != 0 || ELEM_WIDTH > 8 || ELEM_WIDTH < 1 ||
      N_CH < LANES || (N_CH % LANES) != 0) begin : g_bad_cfg
    $error("diff_stream_scatter: N_CH must be K*LANES and ELEM_WIDTH <= 8");
  end

  scatter_state_e state_q, state_d;

  logic [AW-1:0]        addr_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic [KW-1:0]        beat_q;
  logic                 pp_q;
  logic [1:0]           err_q;

  logic [N_CH-1:0]                 wr_en_q;
  logic [N_CH-1:0][AW-1:0]         wr_addr_q;
  logic [N_CH-1:0][ELEM_WIDTH-1:0] wr_din_q;

  logic                            cmd_acc;
  logic                            run_acc;
  logic                            drain_acc;
  logic [LEN_WIDTH-1:0]            remain;
  logic [LEN_WIDTH-1:0]            cnt_next;
  logic [N_CH-1:0]                 map_en;
  logic [N_CH-1:0][ELEM_WIDTH-1:0] map_din;
  logic [CW-1:0]                   map_nwr;

  assign cmd_acc   = cmd_valid && cmd_ready;
  assign run_acc   = s_axis_tvalid && (state_q == RUN);
  assign drain_acc = s_axis_tvalid && (state_q == DRAIN);
  assign remain    = len_q - cnt_q;
  assign cnt_next  = cnt_q + LEN_WIDTH'(map_nwr);

  diff_scatter_lane_map #(
    .LANES      (LANES),
    .N_CH       (N_CH),
    .ELEM_WIDTH (ELEM_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .KW         (KW),
    .CW         (CW)
  ) u_lane_map (
    .beat_idx_i (beat_q),
    .tdata_i    (s_axis_tdata),
    .tkeep_i    (s_axis_tkeep),
    .remain_i   (remain),
    .ch_en_o    (map_en),
    .ch_din_o   (map_din),
    .n_wr_o     (map_nwr)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and handshake/status outputs
  always_comb begin
    state_d       = state_q;
    cmd_ready     = 1'b0;
    s_axis_tready = 1'b0;
    done          = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = RUN;
      end
      RUN: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          if (s_axis_tlast)           state_d = DONE;
          else if (cnt_next >= len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch, element/row bookkeeping and error capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      beat_q <= '0;
      pp_q   <= 1'b0;
      err_q  <= '0;
    end else if (cmd_acc) begin
      addr_q <= cmd_base_addr;
      len_q  <= (cmd_len == '0) ? LEN_WIDTH'(1) : cmd_len;
      cnt_q  <= '0;
      beat_q <= '0;
      pp_q   <= cmd_ping_pong;
      err_q  <= '0;
    end else if (run_acc) begin
      cnt_q <= cnt_next;
      if (beat_q == KW'(K - 1)) begin
        beat_q <= '0;
        addr_q <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
      end else begin
        beat_q <= beat_q + KW'(1);
      end
      if (s_axis_tlast) err_q[SCATTER_ERR_SHORT] <= (cnt_next < len_q);
    end else if (drain_acc && s_axis_tlast) begin
      err_q[SCATTER_ERR_LONG] <= 1'b1;
    end
  end

  // Registered write ports: strobes only for an accepted RUN beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_din_q  <= '0;
    end else begin
      wr_en_q <= run_acc ? map_en : '0;
      for (int c = 0; c < N_CH; c++) begin
        if (run_acc && map_en[c]) begin
          wr_addr_q[c] <= addr_q;
          wr_din_q[c]  <= map_din[c];
        end
      end
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_din       = wr_din_q;
  assign wr_ping_pong = {N_CH{pp_q}};
  assign err          = err_q;

`ifdef DIFF_SCATTER_CSUM_EN
  logic [31:0] beat_sum;
  logic [31:0] csum_q;

  // Sum of the elements enabled in the current beat
  always_comb begin
    beat_sum = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (map_en[c]) beat_sum = beat_sum + 32'(map_din[c]);
    end
  end

  // Running checksum, updated together with the write registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       csum_q <= '0;
    else if (cmd_acc) csum_q <= '0;
    else if (run_acc) csum_q <= csum_q + beat_sum;
  end

  assign csum = csum_q;
`endif

endmodule
